// File: rtl/output_buffer.sv
// Addressed result buffer with a valid/ready drain engine that streams valid entries in address order.
// Optional overwrite detection on an already-valid entry is enabled with OUTPUT_BUFFER_OVERWRITE_CHECK_EN.
module output_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              drain_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              drain_done,
  output logic [ADDR_W:0]   count,
  output logic              overwrite_err
);

  // state      | meaning
  // ST_IDLE    | waiting for drain_req
  // ST_SCAN    | testing valid[ptr], one entry per cycle
  // ST_PRESENT | word at ptr offered to host, held until accepted
  // ST_DONE    | drain finished, drain_done pulses for one cycle
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SCAN    = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;

  logic handshake;
  logic wr_hits_ptr;
  logic cnt_inc;
  logic cnt_dec;

  assign handshake   = (state == ST_PRESENT) && out_valid && out_ready;
  assign wr_hits_ptr = wr_en && (wr_addr == ptr);
  assign cnt_inc     = wr_en && !valid_q[wr_addr];
  // A write landing on the entry being accepted keeps it valid, so no decrement.
  assign cnt_dec     = handshake && !wr_hits_ptr;

  assign busy       = (state != ST_IDLE);
  assign drain_done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      count   <= '0;
    end else begin
      if (handshake) valid_q[ptr] <= 1'b0;
      if (wr_en)     valid_q[wr_addr] <= 1'b1;
      if (cnt_inc && !cnt_dec)      count <= count + 1'b1;
      else if (!cnt_inc && cnt_dec) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (drain_req) begin
            state <= ST_SCAN;
            ptr   <= '0;
          end
        end
        ST_SCAN: begin
          if (valid_q[ptr]) begin
            out_data  <= mem[ptr];
            out_addr  <= ptr;
            out_valid <= 1'b1;
            state     <= ST_PRESENT;
          end else if (&ptr) begin
            state <= ST_DONE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        ST_PRESENT: begin
          if (handshake) begin
            out_valid <= 1'b0;
            if (&ptr) begin
              state <= ST_DONE;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= ST_SCAN;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef OUTPUT_BUFFER_OVERWRITE_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overwrite_err <= 1'b0;
    end else if (wr_en && valid_q[wr_addr] && !(handshake && wr_hits_ptr)) begin
      overwrite_err <= 1'b1;
    end
  end
`else
  assign overwrite_err = 1'b0;
`endif

endmodule

// File: tb/tb_output_buffer.sv
// Directed self-checking bench for output_buffer; overwrite expectations follow OUTPUT_BUFFER_OVERWRITE_CHECK_EN.
module tb_output_buffer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              drain_req;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;
  logic              drain_done;
  logic [ADDR_W:0]   count;
  logic              overwrite_err;

  int checks = 0;
  int failures = 0;

  output_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .drain_req(drain_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .busy(busy), .drain_done(drain_done),
    .count(count), .overwrite_err(overwrite_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_drain();
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      if (out_valid === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      if (drain_done === 1'b1) ok = 1'b1;
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_addr !== 4'h0) begin failures++; $display("FAIL reset_out_addr got=%h exp=0", out_addr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (drain_done !== 1'b0) begin failures++; $display("FAIL reset_drain_done got=%b exp=0", drain_done); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (overwrite_err !== 1'b0) begin failures++; $display("FAIL reset_overwrite_err got=%b exp=0", overwrite_err); end
  endtask

  task automatic test_empty_drain();
    int done_cycle = -1;
    int pulses = 0;
    bit saw_valid = 1'b0;
    bit busy_bad = 1'b0;
    out_ready = 1'b1;
    start_drain();
    for (int c = 1; c <= 20; c++) begin
      if (out_valid === 1'b1) saw_valid = 1'b1;
      if (drain_done === 1'b1) begin pulses++; if (done_cycle < 0) done_cycle = c; end
      if (c <= 17 && busy !== 1'b1) busy_bad = 1'b1;
      if (c == 18 && busy !== 1'b0) busy_bad = 1'b1;
      tick();
    end
    checks++; if (done_cycle != 17) begin failures++; $display("FAIL empty_done_cycle got=%0d exp=17", done_cycle); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL empty_done_pulses got=%0d exp=1", pulses); end
    checks++; if (saw_valid) begin failures++; $display("FAIL empty_out_valid got=1 exp=0"); end
    checks++; if (busy_bad) begin failures++; $display("FAIL empty_busy_window got=bad exp=1_to_17_then_0"); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL empty_count got=%0d exp=0", count); end
  endtask

  task automatic test_two_words();
    logic [ADDR_W-1:0] a_seen [2];
    logic [DATA_W-1:0] d_seen [2];
    logic [ADDR_W:0]   c_seen [2];
    int first_valid = -1;
    int done_cycle = -1;
    int n = 0;
    int pulses = 0;
    write_word(4'd3, 32'hAAAA_0003);
    write_word(4'd12, 32'hBBBB_000C);
    checks++; if (count !== 5'd2) begin failures++; $display("FAIL two_count_pre got=%0d exp=2", count); end
    out_ready = 1'b1;
    start_drain();
    for (int c = 1; c <= 30; c++) begin
      if (out_valid === 1'b1) begin
        if (first_valid < 0) first_valid = c;
        if (n < 2) begin a_seen[n] = out_addr; d_seen[n] = out_data; c_seen[n] = count; end
        n++;
      end
      if (drain_done === 1'b1) begin pulses++; if (done_cycle < 0) done_cycle = c; end
      tick();
    end
    checks++; if (n != 2) begin failures++; $display("FAIL two_word_count got=%0d exp=2", n); end
    checks++; if (first_valid != 5) begin failures++; $display("FAIL two_first_latency got=%0d exp=5", first_valid); end
    checks++; if (a_seen[0] !== 4'd3 || d_seen[0] !== 32'hAAAA_0003) begin failures++; $display("FAIL two_word0 got=%0d/%h exp=3/aaaa0003", a_seen[0], d_seen[0]); end
    checks++; if (a_seen[1] !== 4'd12 || d_seen[1] !== 32'hBBBB_000C) begin failures++; $display("FAIL two_word1 got=%0d/%h exp=12/bbbb000c", a_seen[1], d_seen[1]); end
    checks++; if (c_seen[0] !== 5'd2 || c_seen[1] !== 5'd1) begin failures++; $display("FAIL two_count_seq got=%0d,%0d exp=2,1", c_seen[0], c_seen[1]); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL two_count_post got=%0d exp=0", count); end
    checks++; if (pulses != 1 || done_cycle != 19) begin failures++; $display("FAIL two_done got=%0d@%0d exp=1@19", pulses, done_cycle); end
  endtask

  task automatic test_stall();
    bit ok;
    int unstable = 0;
    write_word(4'd5, 32'h5555_0005);
    out_ready = 1'b0;
    start_drain();
    wait_valid(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_wait_valid got=timeout exp=out_valid"); end
    checks++; if (out_addr !== 4'd5 || out_data !== 32'h5555_0005) begin failures++; $display("FAIL stall_word got=%0d/%h exp=5/55550005", out_addr, out_data); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_addr !== 4'd5 || out_data !== 32'h5555_0005) unstable++;
    end
    checks++; if (unstable != 0) begin failures++; $display("FAIL stall_hold got=%0d_bad_cycles exp=0", unstable); end
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL stall_count_held got=%0d exp=1", count); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_accept_valid got=%b exp=0", out_valid); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL stall_accept_count got=%0d exp=0", count); end
    wait_done(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_done got=timeout exp=drain_done"); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    write_word(4'd5, 32'h1111_1111);
    out_ready = 1'b0;
    start_drain();
    wait_valid(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_wait_valid got=timeout exp=out_valid"); end
    checks++; if (out_data !== 32'h1111_1111) begin failures++; $display("FAIL b2b_presented got=%h exp=11111111", out_data); end
    out_ready = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h2222_2222;
    tick();
    wr_en = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_accept_valid got=%b exp=0", out_valid); end
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL b2b_count got=%0d exp=1", count); end
    checks++; if (overwrite_err !== 1'b0) begin failures++; $display("FAIL b2b_overwrite_err got=%b exp=0", overwrite_err); end
    wait_done(40, ok);
    start_drain();
    wait_valid(40, ok);
    checks++; if (!ok || out_addr !== 4'd5 || out_data !== 32'h2222_2222) begin failures++; $display("FAIL b2b_second_drain got=%0d/%h exp=5/22222222", out_addr, out_data); end
    wait_done(40, ok);
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL b2b_count_post got=%0d exp=0", count); end
  endtask

  task automatic test_overwrite();
    logic exp_err;
`ifdef OUTPUT_BUFFER_OVERWRITE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    write_word(4'd7, 32'h7777_0001);
    checks++; if (overwrite_err !== 1'b0) begin failures++; $display("FAIL ovw_first got=%b exp=0", overwrite_err); end
    write_word(4'd7, 32'h7777_0002);
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL ovw_count got=%0d exp=1", count); end
    tick(); tick(); tick();
    checks++; if (overwrite_err !== exp_err) begin failures++; $display("FAIL ovw_sticky got=%b exp=%b", overwrite_err, exp_err); end
    do_reset();
    checks++; if (overwrite_err !== 1'b0 || count !== 5'd0) begin failures++; $display("FAIL ovw_reset got=%b/%0d exp=0/0", overwrite_err, count); end
  endtask

  task automatic test_reset_mid_drain();
    bit found = 1'b0;
    int order_bad = 0;
    int expect_addr = 0;
    int done_seen = 0;
    for (int i = 0; i < 16; i++) write_word(4'(i), 32'hC0DE_0000 + 32'(i));
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL mid_fill_count got=%0d exp=16", count); end
    out_ready = 1'b1;
    start_drain();
    for (int c = 0; c < 40 && !found; c++) begin
      if (out_valid === 1'b1) begin
        if (out_addr !== 4'(expect_addr) || out_data !== 32'hC0DE_0000 + 32'(expect_addr)) order_bad++;
        if (out_addr === 4'd6) found = 1'b1;
        else expect_addr++;
      end
      if (!found) tick();
    end
    checks++; if (!found) begin failures++; $display("FAIL mid_wait_addr6 got=timeout exp=addr6"); end
    checks++; if (order_bad != 0) begin failures++; $display("FAIL mid_order got=%0d_bad exp=0", order_bad); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    for (int i = 0; i < 20; i++) begin
      if (drain_done === 1'b1 || out_valid === 1'b1) done_seen++;
      tick();
    end
    checks++; if (done_seen != 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", done_seen); end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; drain_req = 1'b0; out_ready = 1'b0;
    test_reset();
    test_empty_drain();
    test_two_words();
    test_stall();
    test_back_to_back();
    test_overwrite();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_buffer.md
# output_buffer

Output buffer downstream of the accumulator stage: captures each finished 32-bit result written by the accumulator (data, 4-bit address, enable) into an addressed entry with a per-entry valid bit. On request, a drain engine scans the entries in address order and streams every valid one to the host over a valid/ready handshake, clearing entries as they are accepted. The accumulator never stalls: writes are accepted every cycle, including during a drain.

## Interface
- DATA_W, 32, result word width
- ADDR_W, 4, entry address width; DEPTH = 2**ADDR_W entries

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe from accumulator (output_buffer_enable)
- wr_addr  in  ADDR_W  write entry (output_buffer_addr)
- wr_data  in  DATA_W  write word (output_data)
- drain_req  in  1  start drain; sampled only in IDLE
- out_valid  out  1  out_data/out_addr hold a word for the host
- out_ready  in  1  host accepts word
- out_data  out  DATA_W  drained word
- out_addr  out  ADDR_W  entry address of drained word
- busy  out  1  drain engine not IDLE
- drain_done  out  1  one-cycle pulse at end of drain
- count  out  ADDR_W+1  number of valid entries
- overwrite_err  out  1  sticky overwrite flag (see Configuration)

## Operation
- Write: wr_en=1 stores wr_data at wr_addr and sets valid[wr_addr]; count increments only if the entry was invalid.
- Storage array is not reset; only valid bits, FSM, and outputs reset.
- FSM states: IDLE, SCAN, PRESENT, DONE; scan pointer ptr (ADDR_W bits).
- IDLE: drain_req=1 -> SCAN, ptr=0. drain_req outside IDLE ignored.
- SCAN: examines valid[ptr] once per cycle.
  - valid -> load out_data=mem[ptr], out_addr=ptr, out_valid=1; -> PRESENT.
  - invalid, ptr<DEPTH-1 -> ptr+1, stay SCAN; invalid, ptr==DEPTH-1 -> DONE.
- PRESENT: hold out_valid/out_data/out_addr stable until out_valid&&out_ready.
  - On handshake: clear valid[ptr], count-1, out_valid=0 next cycle; ptr==DEPTH-1 -> DONE else ptr+1, SCAN.
- DONE: drain_done=1 for that single cycle; -> IDLE.
- Simultaneous write to ptr during handshake: write wins; entry stays valid with new data, count unchanged; emitted word is the old presented data.
- Write to ptr while PRESENT without handshake: storage updated, out_data unchanged (already latched).
- Write to an address already passed in the current drain: stays valid for next drain.
- Write to invalid entry and handshake clearing another entry in same cycle: count unchanged.
- rst mid-drain: FSM -> IDLE, out_valid=0, all valid bits cleared, count=0, no drain_done.

## Timing
- Reset values: out_valid 0, out_data 0, out_addr 0, busy 0, drain_done 0, count 0, overwrite_err 0.
- Write latency: wr_en at edge N -> valid bit and count updated after edge N; visible to a SCAN of that address from cycle N+1.
- drain_req sampled at edge 0 -> SCAN ptr=0 in cycle 1; busy=1 from cycle 1 through DONE cycle.
- Valid entry at ptr found in SCAN cycle k -> out_valid=1 in cycle k+1.
- Empty buffer: drain_done high in cycle DEPTH+1 (17 with defaults), busy low cycle DEPTH+2.
- Per valid entry with out_ready held 1: 2 cycles (SCAN + PRESENT).
- All outputs registered; no combinational path from out_ready to out_valid.

## Configuration
- OUTPUT_BUFFER_OVERWRITE_CHECK_EN defined: overwrite_err sets when wr_en hits an already-valid entry (excluding the handshake-same-cycle case above); cleared only by rst.
- Undefined: overwrite_err tied 0, no detection logic; overwrites silently replace data.

## Test plan
- Reset then drain_req with no writes -> no out_valid, drain_done pulse exactly 17 cycles after drain_req, count stays 0.
- Write 0xAAAA0003 @3, 0xBBBB000C @12, drain, out_ready=1 -> words (3,0xAAAA0003) then (12,0xBBBB000C), count 2->1->0, one drain_done.
- Write @5, drain, out_ready=0 for 10 cycles -> out_valid/out_data/out_addr stable 10 cycles; accept on ready, count 0.
- While (5,0x11111111) presented, write 0x22222222 @5 in handshake cycle -> host gets 0x11111111; second drain yields (5,0x22222222).
- Two writes @7 without drain (macro defined) -> count 1, overwrite_err=1 until rst; macro undefined -> overwrite_err 0.
- Fill entries 0..15, drain, assert rst while out_addr=6 presented -> out_valid 0 next cycle, count 0, busy 0, no drain_done.
